// File: rtl/hsv_core_ctrlstatus_regs_pkg.sv
// Shared CSR numbers, mcountinhibit layout and the bit-masked write merge
// used by the machine counter block.
package hsv_core_ctrlstatus_regs_pkg;

  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;

  localparam int unsigned MCOUNTINHIBIT_CY = 0;
  localparam int unsigned MCOUNTINHIBIT_IR = 2;

  // Only CY and IR are backed by flops; every other bit reads as zero.
  localparam logic [31:0] MCOUNTINHIBIT_MASK =
    (32'd1 << MCOUNTINHIBIT_CY) | (32'd1 << MCOUNTINHIBIT_IR);

  function automatic logic [31:0] merge_bits(input logic [31:0] old_val,
                                             input logic [31:0] wr_data,
                                             input logic [31:0] wr_biten);
    return (old_val & ~wr_biten) | (wr_data & wr_biten);
  endfunction

endpackage

// File: rtl/hsv_core_ctrlstatus_counter64.sv
// 64-bit event counter with per-half bit-masked writes; a write in a cycle
// discards that cycle's increment so software sees exactly what it wrote.
module hsv_core_ctrlstatus_counter64
  import hsv_core_ctrlstatus_regs_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        inc_en_i,
  input  logic [7:0]  inc_amt_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wr_data_i,
  input  logic [31:0] wr_biten_i,
  output logic [63:0] value_o
);

  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic [63:0] sum;

  assign sum = {hi_q, lo_q} + {56'd0, inc_amt_i};

  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) lo_d = merge_bits(lo_q, wr_data_i, wr_biten_i);
      if (wr_hi_i) hi_d = merge_bits(hi_q, wr_data_i, wr_biten_i);
    end else if (inc_en_i) begin
      // Full 64-bit add so the low-to-high carry lands in the same cycle.
      {hi_d, lo_d} = sum;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lo_q <= 32'd0;
      hi_q <= 32'd0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign value_o = {hi_q, lo_q};

endmodule

// File: rtl/hsv_core_ctrlstatus_counters.sv
// Machine counter CSR block: mcycle/minstret, user shadows and mcountinhibit
// behind the ctrlstatus register bus, one-cycle registered responses.
module hsv_core_ctrlstatus_counters
  import hsv_core_ctrlstatus_regs_pkg::*;
(
  input  logic        clk_core,
  input  logic        rst_core_n,
  input  logic        regs_req,
  input  logic        regs_req_is_wr,
  input  logic [15:0] regs_addr,
  input  logic [31:0] regs_wr_data,
  input  logic [31:0] regs_wr_biten,
  output logic        regs_req_stall_rd,
  output logic        regs_req_stall_wr,
  output logic        regs_rd_ack,
  output logic        regs_rd_err,
  output logic [31:0] regs_rd_data,
  output logic        regs_wr_ack,
  output logic        regs_wr_err,
  input  logic        retire
);

  logic [11:0] csr_num;
  logic        addr_ok;
  logic        rd_req;
  logic        wr_req;
  logic        wr_ok;
  logic        rd_hit;
  logic [31:0] rd_val;
  logic        wr_hit;
  logic        cy_wr_lo, cy_wr_hi, ir_wr_lo, ir_wr_hi, inh_wr;
  logic [63:0] cy_val, ir_val;

  logic [31:0] inh_q, inh_d;
  logic        rd_ack_q, wr_ack_q, rd_err_q, wr_err_q;
  logic [31:0] rd_data_q;

  assign csr_num = regs_addr[15:4];
  assign addr_ok = (regs_addr[3:0] == 4'h0);
  assign rd_req  = regs_req & ~regs_req_is_wr;
  assign wr_req  = regs_req & regs_req_is_wr;
  assign wr_ok   = wr_req & addr_ok;

  assign cy_wr_lo = wr_ok && (csr_num == CSR_MCYCLE);
  assign cy_wr_hi = wr_ok && (csr_num == CSR_MCYCLEH);
  assign ir_wr_lo = wr_ok && (csr_num == CSR_MINSTRET);
  assign ir_wr_hi = wr_ok && (csr_num == CSR_MINSTRETH);
  assign inh_wr   = wr_ok && (csr_num == CSR_MCOUNTINHIBIT);
  assign wr_hit   = cy_wr_lo | cy_wr_hi | ir_wr_lo | ir_wr_hi | inh_wr;

  assign inh_d = merge_bits(inh_q, regs_wr_data, regs_wr_biten) & MCOUNTINHIBIT_MASK;

  always_comb begin
    rd_hit = 1'b1;
    rd_val = 32'd0;
    case (csr_num)
      CSR_MCYCLE,    CSR_CYCLE:    rd_val = cy_val[31:0];
      CSR_MCYCLEH,   CSR_CYCLEH:   rd_val = cy_val[63:32];
      CSR_MINSTRET,  CSR_INSTRET:  rd_val = ir_val[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rd_val = ir_val[63:32];
      CSR_MCOUNTINHIBIT:           rd_val = inh_q;
      default:                     rd_hit = 1'b0;
    endcase
    if (!addr_ok) begin
      rd_hit = 1'b0;
      rd_val = 32'd0;
    end
  end

  hsv_core_ctrlstatus_counter64 u_mcycle (
    .clk_i      (clk_core),
    .rst_n_i    (rst_core_n),
    .inc_en_i   (~inh_q[MCOUNTINHIBIT_CY]),
    .inc_amt_i  (8'd1),
    .wr_lo_i    (cy_wr_lo),
    .wr_hi_i    (cy_wr_hi),
    .wr_data_i  (regs_wr_data),
    .wr_biten_i (regs_wr_biten),
    .value_o    (cy_val)
  );

  hsv_core_ctrlstatus_counter64 u_minstret (
    .clk_i      (clk_core),
    .rst_n_i    (rst_core_n),
    .inc_en_i   (~inh_q[MCOUNTINHIBIT_IR]),
    .inc_amt_i  ({7'd0, retire}),
    .wr_lo_i    (ir_wr_lo),
    .wr_hi_i    (ir_wr_hi),
    .wr_data_i  (regs_wr_data),
    .wr_biten_i (regs_wr_biten),
    .value_o    (ir_val)
  );

  // Responses: read data captures the counters as they stand at the request edge.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      rd_ack_q  <= 1'b0;
      wr_ack_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      rd_data_q <= 32'd0;
      inh_q     <= 32'd0;
    end else begin
      rd_ack_q <= rd_req;
      wr_ack_q <= wr_req;
      if (rd_req) begin
        rd_err_q  <= ~rd_hit;
        rd_data_q <= rd_val;
      end
      if (wr_req) wr_err_q <= ~wr_hit;
      if (inh_wr) inh_q <= inh_d;
    end
  end

  assign regs_req_stall_rd = 1'b0;
  assign regs_req_stall_wr = 1'b0;
  assign regs_rd_ack       = rd_ack_q;
  assign regs_rd_err       = rd_err_q;
  assign regs_rd_data      = rd_data_q;
  assign regs_wr_ack       = wr_ack_q;
  assign regs_wr_err       = wr_err_q;

endmodule

// File: tb/tb_hsv_core_ctrlstatus_counters.sv
// Bench for the machine counter CSR block: a reference model predicts every
// response into a queue that a monitor drains, plus directed per-feature checks.
module tb_hsv_core_ctrlstatus_counters;

  logic        clk_core = 1'b0;
  logic        rst_core_n = 1'b0;
  logic        regs_req = 1'b0;
  logic        regs_req_is_wr = 1'b0;
  logic [15:0] regs_addr = 16'd0;
  logic [31:0] regs_wr_data = 32'd0;
  logic [31:0] regs_wr_biten = 32'd0;
  logic        regs_req_stall_rd, regs_req_stall_wr;
  logic        regs_rd_ack, regs_rd_err, regs_wr_ack, regs_wr_err;
  logic [31:0] regs_rd_data;
  logic        retire = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        is_wr;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  logic [63:0] m_cy, m_ir;
  logic [31:0] m_inh;

  hsv_core_ctrlstatus_counters dut (
    .clk_core          (clk_core),
    .rst_core_n        (rst_core_n),
    .regs_req          (regs_req),
    .regs_req_is_wr    (regs_req_is_wr),
    .regs_addr         (regs_addr),
    .regs_wr_data      (regs_wr_data),
    .regs_wr_biten     (regs_wr_biten),
    .regs_req_stall_rd (regs_req_stall_rd),
    .regs_req_stall_wr (regs_req_stall_wr),
    .regs_rd_ack       (regs_rd_ack),
    .regs_rd_err       (regs_rd_err),
    .regs_rd_data      (regs_rd_data),
    .regs_wr_ack       (regs_wr_ack),
    .regs_wr_err       (regs_wr_err),
    .retire            (retire)
  );

  always #5 clk_core = ~clk_core;

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] d,
                                      input logic [31:0] b);
    return (o & ~b) | (d & b);
  endfunction

  // Reference model: evaluates each active edge and queues the expected response.
  task automatic model_loop();
    forever begin
      logic [11:0] c;
      logic        ok, cw, iw;
      logic [63:0] n_cy, n_ir;
      logic [31:0] n_inh;
      exp_t        e;
      @(posedge clk_core);
      if (!rst_core_n) begin
        m_cy = 64'd0; m_ir = 64'd0; m_inh = 32'd0;
      end else begin
        c = regs_addr[15:4];
        ok = (regs_addr[3:0] == 4'h0);
        cw = 1'b0; iw = 1'b0;
        n_cy = m_cy; n_ir = m_ir; n_inh = m_inh;
        if (regs_req) begin
          e.is_wr = regs_req_is_wr; e.err = 1'b1; e.data = 32'd0;
          if (ok && !regs_req_is_wr) begin
            e.err = 1'b0;
            case (c)
              12'hB00, 12'hC00: e.data = m_cy[31:0];
              12'hB80, 12'hC80: e.data = m_cy[63:32];
              12'hB02, 12'hC02: e.data = m_ir[31:0];
              12'hB82, 12'hC82: e.data = m_ir[63:32];
              12'h320:          e.data = m_inh;
              default:          e.err = 1'b1;
            endcase
          end else if (ok) begin
            e.err = 1'b0;
            case (c)
              12'hB00: begin cw = 1'b1; n_cy[31:0]  = mrg(m_cy[31:0],  regs_wr_data, regs_wr_biten); end
              12'hB80: begin cw = 1'b1; n_cy[63:32] = mrg(m_cy[63:32], regs_wr_data, regs_wr_biten); end
              12'hB02: begin iw = 1'b1; n_ir[31:0]  = mrg(m_ir[31:0],  regs_wr_data, regs_wr_biten); end
              12'hB82: begin iw = 1'b1; n_ir[63:32] = mrg(m_ir[63:32], regs_wr_data, regs_wr_biten); end
              12'h320: n_inh = mrg(m_inh, regs_wr_data, regs_wr_biten) & 32'h5;
              default: e.err = 1'b1;
            endcase
          end
          exp_q.push_back(e);
        end
        if (!cw && !m_inh[0]) n_cy = m_cy + 64'd1;
        if (!iw && !m_inh[2] && retire) n_ir = m_ir + 64'd1;
        m_cy = n_cy; m_ir = n_ir; m_inh = n_inh;
      end
    end
  endtask

  // Monitor: every ack must match the queue head in the cycle right after its request.
  task automatic monitor_loop();
    forever begin
      exp_t e;
      @(negedge clk_core);
      if (!rst_core_n) begin
        exp_q.delete();
      end else begin
        total++;
        if (regs_req_stall_rd !== 1'b0 || regs_req_stall_wr !== 1'b0) begin
          bad++;
          $display("FAIL stall got rd=%b wr=%b want 0/0", regs_req_stall_rd, regs_req_stall_wr);
        end
        if (regs_rd_ack || regs_wr_ack) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL spurious_ack got rd_ack=%b wr_ack=%b want none", regs_rd_ack, regs_wr_ack);
          end else begin
            e = exp_q.pop_front();
            if (e.is_wr && (regs_wr_ack !== 1'b1 || regs_rd_ack !== 1'b0 || regs_wr_err !== e.err)) begin
              bad++;
              $display("FAIL sb_write got ack=%b/%b err=%b want wr_ack err=%b",
                       regs_rd_ack, regs_wr_ack, regs_wr_err, e.err);
            end else if (!e.is_wr && (regs_rd_ack !== 1'b1 || regs_wr_ack !== 1'b0 ||
                                      regs_rd_err !== e.err || regs_rd_data !== e.data)) begin
              bad++;
              $display("FAIL sb_read got ack=%b/%b err=%b data=%h want rd_ack err=%b data=%h",
                       regs_rd_ack, regs_wr_ack, regs_rd_err, regs_rd_data, e.err, e.data);
            end
          end
        end else if (exp_q.size() != 0) begin
          total++;
          bad++;
          $display("FAIL missing_ack got none want ack (pending=%0d)", exp_q.size());
          void'(exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_core);
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d, output logic e);
    @(negedge clk_core);
    regs_req = 1'b1; regs_req_is_wr = 1'b0; regs_addr = a;
    @(negedge clk_core);
    regs_req = 1'b0;
    total++;
    if (regs_rd_ack !== 1'b1) begin
      bad++;
      $display("FAIL rd_ack addr=%h got=%b want=1", a, regs_rd_ack);
    end
    d = regs_rd_data;
    e = regs_rd_err;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [31:0] b,
                    output logic e);
    @(negedge clk_core);
    regs_req = 1'b1; regs_req_is_wr = 1'b1; regs_addr = a;
    regs_wr_data = d; regs_wr_biten = b;
    @(negedge clk_core);
    regs_req = 1'b0;
    total++;
    if (regs_wr_ack !== 1'b1) begin
      bad++;
      $display("FAIL wr_ack addr=%h got=%b want=1", a, regs_wr_ack);
    end
    e = regs_wr_err;
  endtask

  task automatic pulse_retire(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_core); retire = 1'b1;
      @(negedge clk_core); retire = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e;
    idle(3);
    total++;
    if ({regs_rd_ack, regs_wr_ack, regs_rd_err, regs_wr_err} !== 4'b0 || regs_rd_data !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs got ack=%b%b err=%b%b data=%h want all 0",
               regs_rd_ack, regs_wr_ack, regs_rd_err, regs_wr_err, regs_rd_data);
    end
    @(negedge clk_core); rst_core_n = 1'b1;
    idle(10);
    rd(16'hB000, d, e);
    total++;
    if (e !== 1'b0 || d < 32'd9 || d > 32'd11) begin
      bad++;
      $display("FAIL mcycle_after_reset got=%0d err=%b want 9..11 err=0", d, e);
    end
    rd(16'hB800, d, e);
    total++;
    if (d !== 32'd0 || e !== 1'b0) begin
      bad++;
      $display("FAIL mcycleh_after_reset got=%h want=0", d);
    end
  endtask

  task automatic test_carry();
    logic [31:0] d; logic e;
    wr(16'hB800, 32'h0, 32'hFFFF_FFFF, e);
    total++;
    if (e !== 1'b0) begin bad++; $display("FAIL wr_err_mcycleh got=%b want=0", e); end
    wr(16'hB000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e);
    total++;
    if (e !== 1'b0) begin bad++; $display("FAIL wr_err_mcycle got=%b want=0", e); end
    rd(16'hB800, d, e);
    total++;
    if (d !== 32'd1) begin bad++; $display("FAIL carry_mcycleh got=%h want=1", d); end
    rd(16'hC800, d, e);
    total++;
    if (d !== 32'd1) begin bad++; $display("FAIL carry_cycleh got=%h want=1", d); end
  endtask

  task automatic test_inhibit();
    logic [31:0] d, v1, v2, c1, c2; logic e;
    wr(16'h3200, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e);
    rd(16'h3200, d, e);
    total++;
    if (d !== 32'h5) begin bad++; $display("FAIL inhibit_mask got=%h want=5", d); end
    pulse_retire(4);
    rd(16'hB020, v1, e);
    rd(16'hB000, c1, e);
    idle(5);
    rd(16'hB020, v2, e);
    rd(16'hB000, c2, e);
    total++;
    if (v1 !== 32'd0 || v2 !== v1) begin
      bad++; $display("FAIL minstret_frozen got=%h,%h want=0,0", v1, v2);
    end
    total++;
    if (c2 !== c1) begin bad++; $display("FAIL mcycle_frozen got=%h want=%h", c2, c1); end
    wr(16'h3200, 32'h0, 32'hFFFF_FFFF, e);
    pulse_retire(3);
    rd(16'hB020, d, e);
    total++;
    if (d !== 32'd3) begin bad++; $display("FAIL minstret_count got=%h want=3", d); end
    rd(16'hC020, d, e);
    total++;
    if (d !== 32'd3) begin bad++; $display("FAIL instret_shadow got=%h want=3", d); end
  endtask

  task automatic test_bitmask();
    logic [31:0] d; logic e;
    wr(16'h3200, 32'h1, 32'hFFFF_FFFF, e);
    wr(16'hB000, 32'h1234_0000, 32'hFFFF_FFFF, e);
    wr(16'hB000, 32'hAAAA_5555, 32'h0000_FFFF, e);
    rd(16'hB000, d, e);
    total++;
    if (d !== 32'h1234_5555) begin bad++; $display("FAIL biten_lo got=%h want=12345555", d); end
    wr(16'hB800, 32'hDEAD_BEEF, 32'hFFFF_0000, e);
    rd(16'hB800, d, e);
    total++;
    if (d !== 32'hDEAD_0001) begin bad++; $display("FAIL biten_hi got=%h want=dead0001", d); end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e;
    wr(16'hC000, 32'h0, 32'hFFFF_FFFF, e);
    total++;
    if (e !== 1'b1) begin bad++; $display("FAIL wr_ro_err got=%b want=1", e); end
    wr(16'hB001, 32'h0, 32'hFFFF_FFFF, e);
    total++;
    if (e !== 1'b1) begin bad++; $display("FAIL wr_lowbits_err got=%b want=1", e); end
    rd(16'hB000, d, e);
    total++;
    if (d !== 32'h1234_5555) begin bad++; $display("FAIL err_no_change got=%h want=12345555", d); end
    rd(16'h07C0, d, e);
    total++;
    if (e !== 1'b1 || d !== 32'd0) begin
      bad++; $display("FAIL rd_unmapped got err=%b data=%h want err=1 data=0", e, d);
    end
    rd(16'hB001, d, e);
    total++;
    if (e !== 1'b1 || d !== 32'd0) begin
      bad++; $display("FAIL rd_lowbits got err=%b data=%h want err=1 data=0", e, d);
    end
    wr(16'h3200, 32'h0, 32'hFFFF_FFFF, e);
  endtask

  task automatic test_back_to_back();
    @(negedge clk_core);
    regs_req = 1'b1; regs_req_is_wr = 1'b1; regs_addr = 16'hB020;
    regs_wr_data = 32'h100; regs_wr_biten = 32'hFFFF_FFFF;
    @(negedge clk_core);
    total++;
    if (regs_wr_ack !== 1'b1) begin bad++; $display("FAIL b2b_wr_ack got=%b want=1", regs_wr_ack); end
    regs_req_is_wr = 1'b0; regs_addr = 16'hB020;
    @(negedge clk_core);
    total++;
    if (regs_rd_ack !== 1'b1 || regs_rd_data !== 32'h100) begin
      bad++; $display("FAIL b2b_rd1 got ack=%b data=%h want 1/100", regs_rd_ack, regs_rd_data);
    end
    regs_addr = 16'hC020;
    @(negedge clk_core);
    total++;
    if (regs_rd_ack !== 1'b1 || regs_rd_data !== 32'h100) begin
      bad++; $display("FAIL b2b_rd2 got ack=%b data=%h want 1/100", regs_rd_ack, regs_rd_data);
    end
    regs_req_is_wr = 1'b1; regs_addr = 16'hB820; regs_wr_data = 32'h5;
    @(negedge clk_core);
    regs_req_is_wr = 1'b0; regs_addr = 16'hB820;
    @(negedge clk_core);
    total++;
    if (regs_rd_ack !== 1'b1 || regs_rd_data !== 32'h5) begin
      bad++; $display("FAIL b2b_rd_hi got ack=%b data=%h want 1/5", regs_rd_ack, regs_rd_data);
    end
    regs_req = 1'b0;
    @(negedge clk_core);
    total++;
    if (regs_rd_ack !== 1'b0 || regs_wr_ack !== 1'b0) begin
      bad++; $display("FAIL b2b_idle_ack got=%b%b want=00", regs_rd_ack, regs_wr_ack);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic e;
    wr(16'h3200, 32'h4, 32'hFFFF_FFFF, e);
    @(negedge clk_core);
    regs_req = 1'b1; regs_req_is_wr = 1'b0; regs_addr = 16'hB000;
    @(posedge clk_core);
    #1;
    rst_core_n = 1'b0;
    regs_req = 1'b0;
    @(negedge clk_core);
    total++;
    if (regs_rd_ack !== 1'b0 || regs_wr_ack !== 1'b0) begin
      bad++; $display("FAIL reset_drops_ack got=%b%b want=00", regs_rd_ack, regs_wr_ack);
    end
    idle(2);
    rst_core_n = 1'b1;
    rd(16'h3200, d, e);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL reset_inhibit got=%h want=0", d); end
    rd(16'hB020, d, e);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL reset_minstret got=%h want=0", d); end
    rd(16'hB820, d, e);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL reset_minstreth got=%h want=0", d); end
    rd(16'hB800, d, e);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL reset_mcycleh got=%h want=0", d); end
    rd(16'hB000, d, e);
    total++;
    if (d > 32'd20) begin bad++; $display("FAIL reset_mcycle got=%0d want<=20", d); end
  endtask

  initial begin
    fork
      model_loop();
      monitor_loop();
    join_none
    test_reset();
    test_carry();
    test_inhibit();
    test_bitmask();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    idle(3);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL leftover_expect got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
